// File: rtl/ps2_scan_decoder_pkg.sv
// Shared encodings for the PS/2 set-2 scan decoder: FSM states, prefix bytes
// and the ASCII constants used by the lookup table.
package ps2_scan_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_e;

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   localparam logic [7:0] ASCII_NONE    = 8'h00;
   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte input and decoded-event output bundle of the PS/2 scan decoder.
// master = byte source / event consumer, slave = decoder.
interface ps2_scan_decoder_if #(
   parameter int unsigned CNT_W = 8
);
   logic [7:0]       byte_data;
   logic             byte_valid;
   logic             evt_valid;
   logic [7:0]       evt_code;
   logic             evt_ext;
   logic             evt_break;
   logic [7:0]       evt_ascii;
   logic             key_down;
   logic [7:0]       held_code;
   logic             held_ext;
   logic [CNT_W-1:0] press_cnt;
   logic             err;

   modport master (
      output byte_data, byte_valid,
      input  evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
             key_down, held_code, held_ext, press_cnt, err
   );

   modport slave (
      input  byte_data, byte_valid,
      output evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
             key_down, held_code, held_ext, press_cnt, err
   );
endinterface

// File: rtl/scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup (upper-case letters, digits,
// space and enter); unmapped codes give 0x00.
module scan2ascii
   import ps2_scan_decoder_pkg::*;
(
   input  logic [7:0] code,
   output logic [7:0] ascii_c
);

   always_comb begin
      ascii_c = ASCII_NONE;
      case (code)
         8'h1C: ascii_c = ASCII_UPPER_A;
         8'h32: ascii_c = ASCII_UPPER_A + 8'd1;
         8'h21: ascii_c = ASCII_UPPER_A + 8'd2;
         8'h23: ascii_c = ASCII_UPPER_A + 8'd3;
         8'h24: ascii_c = ASCII_UPPER_A + 8'd4;
         8'h2B: ascii_c = ASCII_UPPER_A + 8'd5;
         8'h34: ascii_c = ASCII_UPPER_A + 8'd6;
         8'h33: ascii_c = ASCII_UPPER_A + 8'd7;
         8'h43: ascii_c = ASCII_UPPER_A + 8'd8;
         8'h3B: ascii_c = ASCII_UPPER_A + 8'd9;
         8'h42: ascii_c = ASCII_UPPER_A + 8'd10;
         8'h4B: ascii_c = ASCII_UPPER_A + 8'd11;
         8'h3A: ascii_c = ASCII_UPPER_A + 8'd12;
         8'h31: ascii_c = ASCII_UPPER_A + 8'd13;
         8'h44: ascii_c = ASCII_UPPER_A + 8'd14;
         8'h4D: ascii_c = ASCII_UPPER_A + 8'd15;
         8'h15: ascii_c = ASCII_UPPER_A + 8'd16;
         8'h2D: ascii_c = ASCII_UPPER_A + 8'd17;
         8'h1B: ascii_c = ASCII_UPPER_A + 8'd18;
         8'h2C: ascii_c = ASCII_UPPER_A + 8'd19;
         8'h3C: ascii_c = ASCII_UPPER_A + 8'd20;
         8'h2A: ascii_c = ASCII_UPPER_A + 8'd21;
         8'h1D: ascii_c = ASCII_UPPER_A + 8'd22;
         8'h22: ascii_c = ASCII_UPPER_A + 8'd23;
         8'h35: ascii_c = ASCII_UPPER_A + 8'd24;
         8'h1A: ascii_c = ASCII_UPPER_A + 8'd25;
         8'h45: ascii_c = ASCII_DIGIT_0;
         8'h16: ascii_c = ASCII_DIGIT_0 + 8'd1;
         8'h1E: ascii_c = ASCII_DIGIT_0 + 8'd2;
         8'h26: ascii_c = ASCII_DIGIT_0 + 8'd3;
         8'h25: ascii_c = ASCII_DIGIT_0 + 8'd4;
         8'h2E: ascii_c = ASCII_DIGIT_0 + 8'd5;
         8'h36: ascii_c = ASCII_DIGIT_0 + 8'd6;
         8'h3D: ascii_c = ASCII_DIGIT_0 + 8'd7;
         8'h3E: ascii_c = ASCII_DIGIT_0 + 8'd8;
         8'h46: ascii_c = ASCII_DIGIT_0 + 8'd9;
         8'h29: ascii_c = ASCII_SPACE;
         8'h5A: ascii_c = ASCII_CR;
         default: ascii_c = ASCII_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 byte stream to make/break key events, with E0/F0 prefix handling,
// prefix timeout, typematic-repeat filtering and a held-key tracker.
module ps2_scan_decoder
   import ps2_scan_decoder_pkg::*;
#(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned TIMEOUT_CYC   = 1000000,
   parameter int unsigned FILTER_REPEAT = 1
) (
   input logic               clk,
   input logic               rst,
   ps2_scan_decoder_if.slave bus
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_e           state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             emit_c, emit_ext_c, emit_brk_c, abort_c;
   logic             held_match_c, fire_c;
   logic [7:0]       lut_ascii_c;

   logic             evt_valid_q, evt_ext_q, evt_break_q, err_q;
   logic [7:0]       evt_code_q, evt_ascii_q;
   logic             key_down_q, held_ext_q;
   logic [7:0]       held_code_q;
   logic [CNT_W-1:0] press_cnt_q;

   scan2ascii u_scan2ascii (
      .code    (bus.byte_data),
      .ascii_c (lut_ascii_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Prefix sequencing; a byte in the cycle the timeout would fire wins.
   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      emit_c     = 1'b0;
      emit_ext_c = 1'b0;
      emit_brk_c = 1'b0;
      abort_c    = 1'b0;
      if (bus.byte_valid) begin
         to_cnt_d = '0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.byte_data == PREFIX_EXT)      state_d = ST_EXT;
               else if (bus.byte_data == PREFIX_BRK) state_d = ST_BRK;
               else                                  emit_c  = 1'b1;
            end
            ST_EXT: begin
               if (bus.byte_data == PREFIX_BRK) begin
                  state_d = ST_EXT_BRK;
               end else if (bus.byte_data != PREFIX_EXT) begin
                  emit_c     = 1'b1;
                  emit_ext_c = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               state_d = ST_IDLE;
               if (bus.byte_data == PREFIX_EXT || bus.byte_data == PREFIX_BRK) begin
                  abort_c = 1'b1;
               end else begin
                  emit_c     = 1'b1;
                  emit_brk_c = 1'b1;
                  emit_ext_c = (state_q == ST_EXT_BRK);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (to_cnt_q == TO_LAST) begin
            abort_c  = 1'b1;
            state_d  = ST_IDLE;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
      held_match_c = key_down_q && (held_code_q == bus.byte_data) && (held_ext_q == emit_ext_c);
      fire_c       = emit_c && !(!emit_brk_c && (FILTER_REPEAT != 0) && held_match_c);
   end

   // Event, held-key and press-count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt_valid_q <= 1'b0;
         evt_code_q  <= 8'h00;
         evt_ext_q   <= 1'b0;
         evt_break_q <= 1'b0;
         evt_ascii_q <= 8'h00;
         err_q       <= 1'b0;
         key_down_q  <= 1'b0;
         held_code_q <= 8'h00;
         held_ext_q  <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         evt_valid_q <= fire_c;
         err_q       <= abort_c;
         if (fire_c) begin
            evt_code_q  <= bus.byte_data;
            evt_ext_q   <= emit_ext_c;
            evt_break_q <= emit_brk_c;
            evt_ascii_q <= emit_ext_c ? ASCII_NONE : lut_ascii_c;
         end
         if (fire_c && !emit_brk_c) begin
            key_down_q  <= 1'b1;
            held_code_q <= bus.byte_data;
            held_ext_q  <= emit_ext_c;
            press_cnt_q <= press_cnt_q + CNT_W'(1);
         end else if (fire_c && held_match_c) begin
            key_down_q  <= 1'b0;
         end
      end
   end

   assign bus.evt_valid = evt_valid_q;
   assign bus.evt_code  = evt_code_q;
   assign bus.evt_ext   = evt_ext_q;
   assign bus.evt_break = evt_break_q;
   assign bus.evt_ascii = evt_ascii_q;
   assign bus.err       = err_q;
   assign bus.key_down  = key_down_q;
   assign bus.held_code = held_code_q;
   assign bus.held_ext  = held_ext_q;
   assign bus.press_cnt = press_cnt_q;

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the make-event counter.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: idle cycles allowed inside a prefix sequence before abort (min 2).
REQ-003 Parameter FILTER_REPEAT, default 1: 1 = suppress typematic repeat makes of the held key.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 byte_data  input  8  received PS/2 set-2 byte.
REQ-007 byte_valid  input  1  one-cycle strobe; byte_data valid this cycle.
REQ-008 evt_valid  output  1  one-cycle strobe; event fields valid.
REQ-009 evt_code  output  8  scan code of event.
REQ-010 evt_ext  output  1  event code was E0-prefixed.
REQ-011 evt_break  output  1  1 = release, 0 = press.
REQ-012 evt_ascii  output  8  ASCII of evt_code (0 if unmapped or ext).
REQ-013 key_down  output  1  a key is currently held.
REQ-014 held_code  output  8  code of held key (valid when key_down).
REQ-015 held_ext  output  1  ext flag of held key.
REQ-016 press_cnt  output  CNT_W  count of emitted make events.
REQ-017 err  output  1  one-cycle strobe on protocol error or timeout.

Function
REQ-018 FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); bytes processed only when byte_valid=1.
REQ-019 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> emit make(code, ext=0), stay IDLE.
REQ-020 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no event; other -> emit make(code, ext=1), IDLE.
REQ-021 BRK: E0 or F0 -> err, IDLE, no event; other -> emit break(code, ext=0), IDLE.
REQ-022 EXT_BRK: E0 or F0 -> err, IDLE, no event; other -> emit break(code, ext=1), IDLE.
REQ-023 Event outputs registered: evt_valid and fields appear exactly 1 cycle after the accepting byte_valid cycle; fields hold until next event.
REQ-024 Timeout: in any non-IDLE state, cycle counter clears on every byte_valid and increments otherwise; at TIMEOUT_CYC consecutive idle cycles -> IDLE, err pulse, no event.
REQ-025 byte_valid in the same cycle the timeout fires: byte takes priority, timeout ignored.
REQ-026 Make: key_down<=1, held_code/held_ext<=event, press_cnt+=1 (wraps modulo 2^CNT_W).
REQ-027 FILTER_REPEAT=1 and make matches held_code/held_ext while key_down=1 -> no event, no counter increment; FILTER_REPEAT=0 -> every make emitted and counted.
REQ-028 Break matching held_code/held_ext clears key_down; non-matching break emits event, key_down unchanged.
REQ-029 evt_ascii: set-2 letters A-Z -> 0x41-0x5A, digits 0-9 -> 0x30-0x39, 0x29 -> 0x20, 0x5A -> 0x0D; all others and ext=1 -> 0x00.
REQ-030 err and evt_valid never asserted in the same cycle.

Reset
REQ-031 rst=0 asynchronously forces: state IDLE, timeout counter 0, evt_valid 0, evt_code 0, evt_ext 0, evt_break 0, evt_ascii 0, key_down 0, held_code 0, held_ext 0, press_cnt 0, err 0.
REQ-032 Reset mid-sequence (e.g. after E0) discards the partial sequence; first byte after release is decoded from IDLE.

Structure
REQ-033 Shared package holds FSM state encoding, prefix constants 8'hE0 and 8'hF0, and ASCII-table constants.
REQ-034 Scan-to-ASCII lookup is one combinational sub-module, scan2ascii (8-bit code in, 8-bit ASCII out), instantiated once.
REQ-035 FSM, timeout counter, held-key registers and event registers reside in ps2_scan_decoder.

Verification
REQ-036 Bytes 1C, F0, 1C -> make code 1C ascii 41, then break 1C; press_cnt 0->1; key_down 1 then 0.
REQ-037 Bytes E0 75, E0 F0 75 -> make 75 ext=1 ascii 00, break 75 ext=1; key_down returns 0.
REQ-038 FILTER_REPEAT=1, bytes 1C 1C 1C -> one event, press_cnt=1; FILTER_REPEAT=0 -> three events, press_cnt=3.
REQ-039 TIMEOUT_CYC=16, byte F0 then 16 idle cycles -> err pulse, no event; next byte 16 -> make 16 ascii 31.
REQ-040 CNT_W=2, five distinct makes with breaks -> press_cnt sequence 1,2,3,0,1.
REQ-041 rst low for 1 cycle after E0 F0 -> all outputs zero; next byte 45 -> make 45 ext=0 ascii 30.
